// File: rtl/relu_pool_unit_pkg.sv
// relu_pool_unit_pkg: mode codes, FSM states, map geometry and index widths
// shared by relu_pool_unit and its output FIFO.
package relu_pool_unit_pkg;

  typedef enum logic [1:0] {
    MODE_CONV = 2'b00,
    MODE_FC   = 2'b01
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam int DEF_MAP_W = 14;
  localparam int POOL_W    = DEF_MAP_W / 2;
  localparam int RD_IDX_W  = 8;
  localparam int OUT_IDX_W = 6;
  localparam int DEF_ACT_W = 8;

  function automatic logic is_legal_mode(input logic [1:0] m);
    return (m == MODE_CONV) || (m == MODE_FC);
  endfunction

endpackage

// File: rtl/relu_pool_unit_act_out_fifo.sv
// act_out_fifo: synchronous FIFO for pooled activations; exposes its fill count
// so the issuing FSM can reserve space before starting a group.
module act_out_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_pop_s, do_push_s;

  assign do_pop_s  = pop_i && (count_q != '0);
  assign do_push_s = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop_s);

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/relu_pool_unit.sv
// relu_pool_unit: bias + ReLU + requantize + 2x2 max-pool, feeding the act buffer.
// Define RELU_POOL_ROUND_EN for round-half-up requantization; default truncates.
module relu_pool_unit
  import relu_pool_unit_pkg::*;
#(
  parameter int ACC_W      = 24,
  parameter int BIAS_W     = 16,
  parameter int ACT_W      = DEF_ACT_W,
  parameter int MAP_W      = DEF_MAP_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           conv_or_fc,
  input  logic                 relu_activate,
  input  logic [BIAS_W-1:0]    bias,
  input  logic [4:0]           shift,
  output logic                 acc_rd_en,
  output logic [RD_IDX_W-1:0]  acc_rd_idx,
  input  logic [ACC_W-1:0]     acc_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACT_W-1:0]     out_data,
  output logic [OUT_IDX_W-1:0] out_idx,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 overrun
);
  localparam int GRPS  = MAP_W / 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ACT_W + OUT_IDX_W;

  state_e               state_q, state_d;
  mode_e                mode_q;
  logic [2:0]           pr_q, pr_d, grp_q, grp_d, infl_q, infl_d;
  logic [1:0]           sub_q, sub_d;
  logic [BIAS_W-1:0]    bias_q;
  logic [4:0]           shift_q;
  logic                 overrun_q;
  logic                 rd_vld_q, rd_first_q, rd_last_q, rd_final_q;
  logic [OUT_IDX_W-1:0] rd_oidx_q, push_idx_q, oidx_s;
  logic [ACT_W-1:0]     max_q, push_data_q, r_s, grp_max_s;
  logic                 push_q, push_final_q, layer_done_q;
  logic                 start_ok_s, rd_en_s, rd_first_s, rd_last_s, last_grp_s, can_issue_s;
  logic [CNT_W-1:0]     fifo_count_s, fifo_free_s;
  logic [RD_IDX_W-1:0]  rd_idx_s, sub_off_s;
  logic [ENT_W-1:0]     fifo_rdata_s;

  // s = psum + bias at ACC_W+1 bits; negative clamps to 0, then shift and saturate
  function automatic logic [ACT_W-1:0] requant(input logic [ACC_W-1:0] d,
                                                input logic [BIAS_W-1:0] b,
                                                input logic [4:0] sh);
    logic signed [ACC_W:0] s;
    logic [31:0]           mag;
    s = $signed({d[ACC_W-1], d}) + $signed({{(ACC_W+1-BIAS_W){b[BIAS_W-1]}}, b});
    if (s[ACC_W]) mag = 32'd0;
    else          mag = {{(31-ACC_W){1'b0}}, s};
`ifdef RELU_POOL_ROUND_EN
    if (sh != 5'd0) mag = mag + (32'd1 << (sh - 5'd1));
`endif
    mag = mag >> sh;
    if (|mag[31:ACT_W]) return {ACT_W{1'b1}};
    else                return mag[ACT_W-1:0];
  endfunction

  // read address, pooled index and flow-control qualifiers
  always_comb begin
    start_ok_s  = relu_activate && is_legal_mode(conv_or_fc) && (state_q == ST_IDLE);
    fifo_free_s = CNT_W'(FIFO_DEPTH) - fifo_count_s;
    can_issue_s = (sub_q != 2'd0) || (fifo_free_s > CNT_W'(infl_q));
    rd_first_s  = (sub_q == 2'd0);
    rd_last_s   = (mode_q == MODE_FC) || (sub_q == 2'd3);
    last_grp_s  = (mode_q == MODE_FC) || (grp_q == 3'(GRPS - 1));
    case (sub_q)
      2'd1:    sub_off_s = RD_IDX_W'(1);
      2'd2:    sub_off_s = RD_IDX_W'(MAP_W);
      2'd3:    sub_off_s = RD_IDX_W'(MAP_W + 1);
      default: sub_off_s = RD_IDX_W'(0);
    endcase
    if (mode_q == MODE_FC) begin
      rd_idx_s = '0;
      oidx_s   = '0;
    end else begin
      rd_idx_s = RD_IDX_W'(pr_q) * RD_IDX_W'(2 * MAP_W) + RD_IDX_W'({grp_q, 1'b0}) + sub_off_s;
      oidx_s   = OUT_IDX_W'(pr_q) * OUT_IDX_W'(GRPS) + OUT_IDX_W'(grp_q);
    end
  end

  // next-state logic; a group is only opened when the FIFO can absorb it
  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    grp_d   = grp_q;
    sub_d   = sub_q;
    rd_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d = ST_ISSUE;
          grp_d   = 3'd0;
          sub_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        rd_en_s = can_issue_s;
        if (can_issue_s && rd_last_s) begin
          sub_d = 2'd0;
          if (last_grp_s) state_d = ST_DRAIN;
          else            grp_d   = grp_q + 3'd1;
        end else if (can_issue_s) begin
          sub_d = sub_q + 2'd1;
        end else begin
          sub_d = sub_q;
        end
      end
      ST_DRAIN: begin
        if (push_q && push_final_q) begin
          state_d = ST_IDLE;
          if (mode_q == MODE_CONV) pr_d = (pr_q == 3'd6) ? 3'd0 : pr_q + 3'd1;
          else                     pr_d = pr_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    infl_d = infl_q + 3'(rd_en_s && rd_first_s) - 3'(push_q);
  end

  // control state, sampled job parameters and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_CONV;
      pr_q      <= 3'd0;
      grp_q     <= 3'd0;
      sub_q     <= 2'd0;
      infl_q    <= 3'd0;
      bias_q    <= '0;
      shift_q   <= 5'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      grp_q   <= grp_d;
      sub_q   <= sub_d;
      infl_q  <= infl_d;
      if (start_ok_s) begin
        mode_q  <= mode_e'(conv_or_fc);
        bias_q  <= bias;
        shift_q <= shift;
      end
      if (relu_activate && (state_q != ST_IDLE)) overrun_q <= 1'b1;
    end
  end

  assign r_s       = requant(acc_rd_data, bias_q, shift_q);
  assign grp_max_s = (rd_first_q || (r_s > max_q)) ? r_s : max_q;

  // read-return tags follow the regfile latency; group max lands in the FIFO one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q     <= 1'b0;
      rd_first_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_final_q   <= 1'b0;
      rd_oidx_q    <= '0;
      max_q        <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_idx_q   <= '0;
      push_final_q <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      rd_vld_q     <= rd_en_s;
      rd_first_q   <= rd_first_s;
      rd_last_q    <= rd_last_s;
      rd_final_q   <= rd_last_s && last_grp_s;
      rd_oidx_q    <= oidx_s;
      if (rd_vld_q) max_q <= grp_max_s;
      push_q       <= rd_vld_q && rd_last_q;
      push_data_q  <= grp_max_s;
      push_idx_q   <= rd_oidx_q;
      push_final_q <= rd_vld_q && rd_last_q && rd_final_q;
      layer_done_q <= rd_vld_q && rd_last_q && rd_final_q &&
                      ((mode_q == MODE_FC) || (pr_q == 3'd6));
    end
  end

  act_out_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i ({push_data_q, push_idx_q}),
    .pop_i   (out_ready),
    .rdata_o (fifo_rdata_s),
    .valid_o (out_valid),
    .count_o (fifo_count_s)
  );

  assign out_data   = fifo_rdata_s[ENT_W-1:OUT_IDX_W];
  assign out_idx    = fifo_rdata_s[OUT_IDX_W-1:0];
  assign acc_rd_en  = rd_en_s;
  assign acc_rd_idx = rd_en_s ? rd_idx_s : '0;
  assign busy       = (state_q != ST_IDLE);
  assign layer_done = layer_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_relu_pool_unit.sv
// tb_relu_pool_unit: directed bench with a scoreboard model of the pooled output stream.
`timescale 1ns/1ps
module tb_relu_pool_unit;
  localparam logic [1:0] CONV = 2'b00;
  localparam logic [1:0] FC   = 2'b01;

  logic        clk = 1'b0;
  logic        rst, relu_activate, out_ready;
  logic [1:0]  conv_or_fc;
  logic [15:0] bias;
  logic [4:0]  shift;
  logic        acc_rd_en, out_valid, busy, layer_done, overrun;
  logic [7:0]  acc_rd_idx, out_data;
  logic [23:0] acc_rd_data = 24'd0;
  logic [5:0]  out_idx;

  int psum [196];
  int exp_d[$], exp_i[$], got_d[$], got_i[$];
  int checks = 0, failures = 0;
  int m_pr = 0, cyc = 0, ld_cnt = 0, ld_cyc = -1, idx48_cyc = -1;

  relu_pool_unit dut (
    .clk(clk), .rst(rst), .conv_or_fc(conv_or_fc), .relu_activate(relu_activate),
    .bias(bias), .shift(shift), .acc_rd_en(acc_rd_en), .acc_rd_idx(acc_rd_idx),
    .acc_rd_data(acc_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .busy(busy), .layer_done(layer_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // accumulator regfile: data one cycle after the strobe
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= 24'(psum[acc_rd_idx]);
  end

  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int model_r(input int d, input int b, input int sh);
    longint s;
    s = longint'(d) + longint'(b);
    if (s < 0) return 0;
`ifdef RELU_POOL_ROUND_EN
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
    s = s >> sh;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  task automatic model_conv(input int b, input int sh);
    int off [4] = '{0, 1, 14, 15};
    for (int c = 0; c < 7; c++) begin
      int m = 0;
      for (int k = 0; k < 4; k++) begin
        int v = model_r(psum[m_pr * 28 + 2 * c + off[k]], b, sh);
        if (v > m) m = v;
      end
      exp_d.push_back(m);
      exp_i.push_back(m_pr * 7 + c);
    end
    m_pr = (m_pr == 6) ? 0 : m_pr + 1;
  endtask

  // output scoreboard and event monitor
  always @(negedge clk) begin : cmp
    int ed, ei;
    cyc++;
    if (!rst) begin
      if (layer_done) begin ld_cnt++; ld_cyc = cyc; end
      if (out_valid && out_idx == 6'd48 && idx48_cyc < 0) idx48_cyc = cyc;
      if (out_valid && out_ready) begin
        got_d.push_back(int'(out_data));
        got_i.push_back(int'(out_idx));
        if (exp_d.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_out got idx=%0d data=%0d exp none", out_idx, out_data);
        end else begin
          ed = exp_d.pop_front();
          ei = exp_i.pop_front();
          check("out_data", out_data, ed);
          check("out_idx", out_idx, ei);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] mode, input int b, input int sh, input bit accepted);
    conv_or_fc = mode; bias = 16'(b); shift = 5'(sh); relu_activate = 1'b1;
    if (accepted && mode == CONV) model_conv(b, sh);
    if (accepted && mode == FC) begin
      exp_d.push_back(model_r(psum[0], b, sh));
      exp_i.push_back(0);
    end
    tick(1);
    relu_activate = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || exp_d.size() != 0) && n < 600) begin @(negedge clk); n++; end
    check({nm, "_busy"}, busy, 0);
    check({nm, "_pending"}, exp_d.size(), 0);
    @(negedge clk);
    check({nm, "_empty_valid"}, out_valid, 0);
    tick(1);
  endtask

  task automatic clear_log();
    got_d.delete(); got_i.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ld_base;
    rst = 1'b1; out_ready = 1'b1; relu_activate = 1'b0;
    conv_or_fc = 2'b00; bias = 16'd0; shift = 5'd0;
    for (int i = 0; i < 196; i++) psum[i] = i;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd_en", acc_rd_en, 0);
    check("rst_rd_idx", acc_rd_idx, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    rst = 1'b0;
    tick(1);

    // ramp psums: 15,17,..,27 and 30 busy cycles
    clear_log();
    start(CONV, 0, 0, 1);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin n++; @(negedge clk); end
    check("t1_busy_cycles", n, 30);
    wait_idle("t1");
    check("t1_count", got_d.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check("t1_lit_data", got_d[i], 15 + 2 * i);
      check("t1_lit_idx", got_i[i], i);
    end
    check("t1_no_layer_done", ld_cnt, 0);

    // ReLU clamps negative sums
    for (int i = 0; i < 196; i++) psum[i] = -5;
    clear_log();
    start(CONV, 3, 0, 1);
    wait_idle("t2");
    for (int i = 0; i < 7; i++) check("t2_lit_zero", got_d[i], 0);
    check("t2_lit_idx", got_i[0], 7);

    // saturation
    for (int i = 0; i < 196; i++) psum[i] = 70000;
    clear_log();
    start(CONV, 0, 4, 1);
    wait_idle("t3");
    check("t3_lit_sat", got_d[0], 255);
    check("t3_lit_idx", got_i[0], 14);

    // requant shift: 24>>4
    for (int i = 0; i < 196; i++) psum[i] = 24;
    clear_log();
    start(CONV, 0, 4, 1);
    wait_idle("t4");
`ifdef RELU_POOL_ROUND_EN
    check("t4_lit_round", got_d[0], 2);
`else
    check("t4_lit_trunc", got_d[0], 1);
`endif

    // backpressure: two pairs with out_ready low fill the FIFO and stall issue
    for (int i = 0; i < 196; i++) psum[i] = i;
    clear_log();
    out_ready = 1'b0;
    start(CONV, 0, 0, 1);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("t5_first_done", busy, 0);
    tick(1);
    start(CONV, 0, 0, 1);
    tick(60);
    @(negedge clk);
    check("t5_stall_busy", busy, 1);
    check("t5_stall_rd_en", acc_rd_en, 0);
    check("t5_held_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_idle("t5");
    check("t5_count", got_i.size(), 14);
    check("t5_lit_first_idx", got_i[0], 28);
    check("t5_lit_first_data", got_d[0], 127);
    check("t5_lit_last_idx", got_i[13], 41);

    // illegal mode start ignored without flag
    start(2'b10, 0, 0, 0);
    check("ill_busy", busy, 0);
    check("ill_overrun", overrun, 0);

    // overrun on pr=6 pair, which also ends the map
    clear_log();
    ld_base = ld_cnt;
    start(CONV, 0, 0, 1);
    tick(9);
    start(CONV, 0, 0, 0);
    check("t6_overrun", overrun, 1);
    wait_idle("t6");
    check("t6_count", got_d.size(), 7);
    check("t6_lit_idx48", got_i[6], 48);
    check("t6_layer_done_once", ld_cnt - ld_base, 1);

    // reset mid-pair
    start(CONV, 0, 0, 1);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_d.delete(); exp_i.delete();
    m_pr = 0;
    check("t7_valid", out_valid, 0);
    check("t7_busy", busy, 0);
    check("t7_overrun_cleared", overrun, 0);
    tick(1);

    // full map: seven starts 32 cycles apart
    clear_log();
    ld_base = ld_cnt;
    idx48_cyc = -1;
    for (int p = 0; p < 7; p++) begin
      start(CONV, 0, 0, 1);
      @(negedge clk);
      if (p == 0) begin
        check("t8_first_rd_en", acc_rd_en, 1);
        check("t8_first_rd_idx", acc_rd_idx, 0);
      end
      tick(31);
    end
    wait_idle("t8");
    check("t8_count", got_i.size(), 49);
    check("t8_lit_idx0", got_i[0], 0);
    check("t8_lit_idx48", got_i[48], 48);
    check("t8_layer_done_once", ld_cnt - ld_base, 1);
    check("t8_layer_done_at_write", idx48_cyc - ld_cyc, 1);

    // FC single value
    psum[0] = -1;
    clear_log();
    ld_base = ld_cnt;
    start(FC, 2, 0, 1);
    wait_idle("t9");
    check("t9_count", got_d.size(), 1);
    check("t9_lit_data", got_d[0], 1);
    check("t9_lit_idx", got_i[0], 0);
    check("t9_layer_done", ld_cnt - ld_base, 1);

    // FC leaves the pair counter alone
    psum[0] = 0;
    clear_log();
    start(CONV, 0, 0, 1);
    wait_idle("t10");
    check("t10_lit_idx", got_i[0], 0);
    check("t10_lit_data", got_d[0], 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
